// File: rtl/zeroriscy_data_resp_if.sv
// rtl/zeroriscy_data_resp_if.sv - core data port bundle (req/gnt/rvalid) between a core and the data responder
interface zeroriscy_data_resp_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/zeroriscy_data_resp.sv
// rtl/zeroriscy_data_resp.sv - data-bus responder: word RAM plus result/flag mailbox, optional wait states
// Optional feature: DATA_RESP_ERR_EN flags decode misses on data_err_o.
module zeroriscy_data_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter logic [31:0] RESULT_ADDR = 32'h0010_1000,
    parameter logic [31:0] FLAG_ADDR   = 32'h0010_1004,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    zeroriscy_data_resp_if.slave        data,
    output logic [31:0]                 mem_result,
    output logic [31:0]                 mem_flag
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_END   = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        gnt;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] result_q;
    logic [31:0] flag_q;
    logic [31:0] ram_q [DEPTH_WORDS];

    logic [31:0]      word_addr;
    logic [31:0]      ram_off;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_hit;
    logic             res_hit;
    logic             flag_hit;
    logic             unused_addr_bits;

    assign word_addr = {data.data_addr_i[31:2], 2'b00};
    assign ram_off   = word_addr - BASE_ADDR;
    assign ram_idx   = ram_off[IDX_W+1:2];
    assign ram_hit   = ({1'b0, word_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, word_addr} < RAM_END);
    assign res_hit   = (word_addr == RESULT_ADDR);
    assign flag_hit  = (word_addr == FLAG_ADDR);
    assign unused_addr_bits = ^{data.data_addr_i[1:0], ram_off[31:IDX_W+2], ram_off[1:0]};

    // Grant is combinational so a zero-wait request is accepted in the cycle it appears.
    always_comb begin
        gnt = 1'b0;
        if (data.data_req_i) begin
            if (state_q == S_IDLE) gnt = (WAIT_CYCLES == 0);
            else                   gnt = (cnt_q == 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (data.data_req_i && (WAIT_CYCLES != 0)) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (!data.data_req_i || (cnt_q == 4'd0)) state_q <= S_IDLE;
                    else                                     cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Mailbox writes land on the grant edge, so a load granted next cycle already sees them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            result_q <= 32'd0;
            flag_q   <= 32'd0;
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                if (!data.data_we_i) begin
                    if (ram_hit)       rdata_q <= ram_q[ram_idx];
                    else if (res_hit)  rdata_q <= result_q;
                    else if (flag_hit) rdata_q <= flag_q;
                    else               rdata_q <= 32'hDEAD_BEEF;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (data.data_be_i[b] && res_hit)  result_q[8*b +: 8] <= data.data_wdata_i[8*b +: 8];
                        if (data.data_be_i[b] && flag_hit) flag_q[8*b +: 8]   <= data.data_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (gnt && data.data_we_i && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (data.data_be_i[b]) ram_q[ram_idx][8*b +: 8] <= data.data_wdata_i[8*b +: 8];
            end
        end
    end

`ifdef DATA_RESP_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  err_q <= 1'b0;
        else if (gnt) err_q <= !(ram_hit || res_hit || flag_hit);
    end

    assign data.data_err_o = err_q;
`else
    assign data.data_err_o = 1'b0;
`endif

    assign data.data_gnt_o    = gnt;
    assign data.data_rvalid_o = rvalid_q;
    assign data.data_rdata_o  = rdata_q;
    assign mem_result         = result_q;
    assign mem_flag           = flag_q;
endmodule
